// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: command-driven controller for a bank of WIDTH JK cells.
// A command (opcode, data, step count) is latched in IDLE. The bank is then
// driven for Count steps in RUN, and completion is signalled with a one-cycle
// Done pulse in DONE.
// Optional feature: define JKSEQ_ABORT_EN to add the Abort input. Abort stops
// a RUN early: Q holds for that cycle and the FSM goes on to DONE.
module jk_bank_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Cmd,
  input  logic [WIDTH-1:0] Data,
  input  logic [3:0]       Count,
`ifdef JKSEQ_ABORT_EN
  input  logic             Abort,
`endif
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_CLEAR  = 3'd1,
    OP_SET    = 3'd2,
    OP_LOAD   = 3'd3,
    OP_TOGGLE = 3'd4,
    OP_UP     = 3'd5,
    OP_DOWN   = 3'd6,
    OP_SHIFT  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  op_t              op;
  logic [WIDTH-1:0] dat;
  logic [3:0]       remaining;
  logic             abort_now;
  logic [WIDTH-1:0] j_op;
  logic [WIDTH-1:0] k_op;
  logic             carry;

`ifdef JKSEQ_ABORT_EN
  assign abort_now = Abort;
`else
  assign abort_now = 1'b0;
`endif

  // Per-opcode J/K drive, derived only from the current Q and the latched command
  always_comb begin
    j_op  = '0;
    k_op  = '0;
    carry = 1'b1;
    case (op)
      OP_HOLD: begin
        j_op = '0;
        k_op = '0;
      end
      OP_CLEAR: begin
        j_op = '0;
        k_op = '1;
      end
      OP_SET: begin
        j_op = '1;
        k_op = '0;
      end
      OP_LOAD: begin
        j_op = dat;
        k_op = ~dat;
      end
      OP_TOGGLE: begin
        j_op = '1;
        k_op = '1;
      end
      OP_UP: begin
        // A bit toggles when every lower bit is 1; bit 0 always toggles
        for (int i = 0; i < WIDTH; i++) begin
          j_op[i] = carry;
          carry   = carry & Q[i];
        end
        k_op = j_op;
      end
      OP_DOWN: begin
        // A bit toggles when every lower bit is 0; bit 0 always toggles
        for (int i = 0; i < WIDTH; i++) begin
          j_op[i] = carry;
          carry   = carry & ~Q[i];
        end
        k_op = j_op;
      end
      OP_SHIFT: begin
        // Right shift; the latched serial-in bit enters at the MSB
        j_op = {dat[0], Q[WIDTH-1:1]};
        k_op = ~{dat[0], Q[WIDTH-1:1]};
      end
      default: begin
        j_op = '0;
        k_op = '0;
      end
    endcase
  end

  // Only RUN drives the bank; IDLE, DONE and an aborted cycle hold Q
  always_comb begin
    J = '0;
    K = '0;
    if (state == S_RUN && !abort_now) begin
      J = j_op;
      K = k_op;
    end
  end

  // Sequencer FSM with registered Busy/Done; reset overrides any Start
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= S_IDLE;
      op        <= OP_HOLD;
      remaining <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            op        <= op_t'(Cmd);
            remaining <= Count;
            Busy      <= 1'b1;
            if (Count != 4'd0) begin
              state <= S_RUN;
            end else begin
              state <= S_DONE;
              Done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (abort_now || remaining == 4'd1) begin
            state     <= S_DONE;
            remaining <= '0;
            Done      <= 1'b1;
          end else begin
            remaining <= remaining - 4'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

  // LOAD value and serial-in bit, captured with an accepted command
  always_ff @(posedge Clock) begin
    if (state == S_IDLE && Start) begin
      dat <= Data;
    end
  end

  // JK bank: 00 hold, 01 reset, 10 set, 11 toggle
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      Q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({J[i], K[i]})
          2'b00:   Q[i] <= Q[i];
          2'b01:   Q[i] <= 1'b0;
          2'b10:   Q[i] <= 1'b1;
          default: Q[i] <= ~Q[i];
        endcase
      end
    end
  end

endmodule

// File: doc/jk_bank_sequencer.md
# jk_bank_sequencer

Command-driven controller for a bank of JK flip-flops: it accepts one command at a time and computes the per-bit J/K drive each cycle for a fixed number of steps. The supported operations are clear, set, load, toggle, count up/down and shift. The bank (WIDTH JK cells, same JK semantics as the lab flip-flop: 00 hold, 01 reset, 10 set, 11 toggle) is instantiated inside the block. This is the sequencing layer above the Week 6 flip-flop work and serves as the counter/register engine for later labs.

## Interface
- WIDTH, 4: number of JK cells in the bank (2..16)
- Clock  input  1  rising-edge clock
- Reset  input  1  synchronous, active-low reset
- Start  input  1  command request; accepted only in IDLE
- Cmd  input  3  opcode, sampled with Start
- Data  input  WIDTH  LOAD value; Data[0] is the SHIFT serial-in; sampled with Start
- Count  input  4  number of steps to execute (0..15), sampled with Start
- J  output  WIDTH  J drive applied to the bank this cycle
- K  output  WIDTH  K drive applied to the bank this cycle
- Q  output  WIDTH  bank state
- Busy  output  1  high in RUN and DONE
- Done  output  1  one-cycle completion pulse

## Operation
- Opcodes:
  - 0 HOLD: J=K=0
  - 1 CLEAR: J=0, K=1
  - 2 SET: J=1, K=0
  - 3 LOAD: J=D, K=~D, where D is the latched Data
  - 4 TOGGLE: J=K=1
  - 5 UP: J[i]=K[i]=&Q[i-1:0], with bit 0 always 1
  - 6 DOWN: J[i]=K[i]=&~Q[i-1:0], with bit 0 always 1
  - 7 SHIFT right: J[i]=Q[i+1], K[i]=~Q[i+1]; the MSB uses the latched Data[0]
- Bank update each edge: Q[i] follows the JK table using J[i] and K[i].
- FSM states: IDLE, RUN, DONE.
  - IDLE with Start=1: latch Cmd, Data and Count. Go to RUN if Count≠0, else go to DONE.
  - RUN: J/K are driven per the latched opcode. On each edge, Q updates and the remaining count decrements. When remaining==1 at an edge, go to DONE.
  - DONE: J=K=0 and Done=1 for exactly one cycle, then IDLE.
- In IDLE and DONE, J=K=0, so Q holds.
- Start in RUN or DONE is ignored and is not queued.
- UP wraps all-ones→0. DOWN wraps 0→all-ones.
- CLEAR, SET and LOAD are idempotent across repeated steps.

## Timing
- Reset low at an edge forces the following, overriding any state (including mid-RUN) and any Start in the same cycle:
  - Q=0, J=0, K=0
  - Busy=0, Done=0
  - state=IDLE
  - remaining=0
- Start accepted at edge E0 → RUN from E0. J/K are valid combinationally in the cycles before E1..E_Count, and Q reflects step n after edge E_n.
- Done is high in the cycle after E_Count. Busy falls together with Done, so Start is accepted at the following edge. Command-to-command spacing is Count+2 cycles.
- Count=0: DONE in the cycle after E0, and Q is unchanged.
- J and K depend combinationally on the current Q and the latched opcode only, never on the live Cmd or Data inputs.

## Configuration
- JKSEQ_ABORT_EN defined: adds the input port Abort (1 bit).
  - Abort=1 in RUN forces J=K=0 that cycle, so Q holds at the next edge.
  - The FSM then goes to DONE, with Done pulsing as normal.
  - Abort is ignored in IDLE and DONE.
- JKSEQ_ABORT_EN undefined: no Abort port, and every RUN completes its full Count.

## Test plan
- Reset=0 for 2 cycles with Start=1, Cmd=2 → Q=0000, Busy=0, Done=0. Release Reset, then SET with Count=1 → Q=1111 after one step, and Done is high in the next cycle.
- UP from Q=1110 with Count=3 → Q sequence 1111, 0000, 0001, showing wrap. DOWN from 0001 with Count=2 → 0000, 1111.
- LOAD Data=1010, Count=1 → Q=1010. Then SHIFT Data[0]=1, Count=2 → 1101, 1110.
- TOGGLE with Count=0 from Q=0101 → no Q change, Done pulse in the cycle after Start, Busy high for that one cycle.
- Start=1 held continuously during a Count=4 UP from 0000 → Q=0100 at Done, and no second command starts until after Done. Reset=0 asserted mid-RUN (after 2 steps) → Q=0000 and IDLE at the next edge, with no Done pulse.
- With JKSEQ_ABORT_EN: UP from 0000 with Count=8, Abort=1 during the 3rd RUN cycle → Q stays 0010, and Done pulses in the following cycle.
